// File: rtl/quantize_nf4_pkg.sv
// NF4 quantizer shared constants: widths, zero-level code and threshold table.
// Latency: n/a (package only).
// Backpressure: n/a.
package quantize_nf4_pkg;

  localparam int SAMPLE_W      = 8;
  localparam int CODE_W        = 4;
  localparam int CMP_W         = 18;
  localparam int NF4_ZERO_CODE = 7;
  localparam int NF4_NTHR      = 15;

  // Midpoints between adjacent NF4 levels, Q0.8, ascending
  function automatic logic signed [CMP_W-1:0] nf4_thr(input int k);
    case (k)
      0:       nf4_thr = -18'sd217;
      1:       nf4_thr = -18'sd156;
      2:       nf4_thr = -18'sd118;
      3:       nf4_thr = -18'sd87;
      4:       nf4_thr = -18'sd60;
      5:       nf4_thr = -18'sd35;
      6:       nf4_thr = -18'sd12;
      7:       nf4_thr = 18'sd10;
      8:       nf4_thr = 18'sd31;
      9:       nf4_thr = 18'sd52;
      10:      nf4_thr = 18'sd75;
      11:      nf4_thr = 18'sd100;
      12:      nf4_thr = 18'sd128;
      13:      nf4_thr = 18'sd165;
      default: nf4_thr = 18'sd221;
    endcase
  endfunction

endpackage

// File: rtl/nf4_threshold_encoder.sv
// Maps one Q2.6 sample to an NF4 code relative to the block absmax.
// Latency: purely combinational.
// Backpressure: none (no handshake).
module nf4_threshold_encoder
  import quantize_nf4_pkg::*;
(
  input  logic [SAMPLE_W-1:0] x,
  input  logic [8:0]          absmax,
  output logic [CODE_W-1:0]   code
);

  logic signed [CMP_W-1:0] xs;
  logic signed [CMP_W-1:0] am;
  logic signed [CMP_W-1:0] rhs;
  logic [CODE_W-1:0]       cnt_v;

  // x is scaled by 256 so it lines up with the Q0.8 thresholds times absmax
  assign xs = CMP_W'($signed(x)) <<< 8;
  assign am = $signed({{(CMP_W-9){1'b0}}, absmax});

  // Count thresholds strictly exceeded; ties fall to the lower code
  always_comb begin
    cnt_v = '0;
    rhs   = '0;
    for (int k = 0; k < NF4_NTHR; k++) begin
      rhs = nf4_thr(k) * am;
      if (xs > rhs) cnt_v = cnt_v + 1'b1;
    end
    if (absmax == 9'd0) code = CODE_W'(NF4_ZERO_CODE);
    else                code = cnt_v;
  end

endmodule

// File: rtl/quantize_nf4_q2_6.sv
// Block NF4 quantizer: collects BLOCK_SIZE Q2.6 samples, then emits one code per sample with block absmax.
// Latency: first output the cycle after the last input beat; codes are combinational from the buffer.
// Backpressure: in_ready low for the whole emit phase; outputs hold while out_ready is low.
module quantize_nf4_q2_6
  import quantize_nf4_pkg::*;
#(
  parameter int BLOCK_SIZE = 16
) (
  input  logic                ap_clk,
  input  logic                ap_rst,
  input  logic [SAMPLE_W-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [CODE_W-1:0]   out_code,
  output logic [7:0]          out_scale,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last
);

  localparam int CW = $clog2(BLOCK_SIZE);
  localparam logic [CW-1:0] LAST = CW'(BLOCK_SIZE - 1);

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] EMIT    = 1'b1;

  logic [0:0]          state;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       idx;
  logic [8:0]          absmax;
  logic [8:0]          mag;
  logic [SAMPLE_W-1:0] sample_buf [BLOCK_SIZE];
  logic [CODE_W-1:0]   enc_code;
  logic                in_fire;
  logic                out_fire;
  logic                emit;

  assign emit     = (state == EMIT);
  assign in_ready = (state == COLLECT);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = emit && out_ready;

  // 9-bit magnitude so that -128 maps to 128 without overflow
  assign mag = in_data[SAMPLE_W-1] ? (9'd0 - {1'b1, in_data}) : {1'b0, in_data};

  // Sample storage; stale contents after reset are never emitted
  always_ff @(posedge ap_clk) begin
    if (in_fire) sample_buf[cnt] <= in_data;
  end

  // Collect/emit sequencing, write/read pointers and running absmax
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state  <= COLLECT;
      cnt    <= '0;
      idx    <= '0;
      absmax <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (in_fire) begin
            cnt <= cnt + 1'b1;
            if (mag > absmax) absmax <= mag;
            if (cnt == LAST) state <= EMIT;
          end
        end
        default: begin
          if (out_fire) begin
            idx <= idx + 1'b1;
            if (idx == LAST) begin
              state  <= COLLECT;
              absmax <= '0;
              idx    <= '0;
            end
          end
        end
      endcase
    end
  end

  nf4_threshold_encoder u_enc (
    .x      (sample_buf[idx]),
    .absmax (absmax),
    .code   (enc_code)
  );

  // Outputs are forced to zero outside the emit phase
  assign out_valid = emit;
  assign out_code  = emit ? enc_code : '0;
  assign out_scale = emit ? absmax[7:0] : 8'd0;
  assign out_last  = emit && (idx == LAST);

endmodule
